// File: rtl/logic_op_pkg.sv
// Shared types and helpers for the registered bitwise-op stream block.
package logic_op_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Burst fold operator: NAND bursts fold with AND so the burst result
    // is the AND of the individual NAND beat results.
    function automatic op_e fold_op(input op_e op);
        case (op)
            OP_OR:   return OP_OR;
            OP_XOR:  return OP_XOR;
            default: return OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/logic_op_alu.sv
// Combinational datapath: per-beat result and its fold into the accumulator.
module logic_op_alu
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] f
);

    // Beat result r = a op b
    always_comb begin
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
    end

    // Fold the beat result into the running accumulator
    always_comb begin
        case (fold_op(op))
            OP_OR:   f = acc | r;
            OP_XOR:  f = acc ^ r;
            default: f = acc & r;
        endcase
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Registered WIDTH-bit bitwise op with valid/ready handshake and optional
// multi-beat accumulation of a burst into a single output word.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state, state_nxt;
    op_e              op_q;
    op_e              beat_op;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] r, f;
    logic             beat;
    logic             closes;
    logic             load;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] res_beats;

    // Mid-burst the latched op wins; in_op only matters on the first beat.
    assign beat_op  = (state == ACCUM) ? op_q : op_e'(in_op);
    assign in_ready = !rst && !(out_valid && !out_ready);
    assign beat     = in_valid && in_ready;
    // in_acc=0 mid-burst closes the burst just like in_last.
    assign closes   = !in_acc || in_last;
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    logic_op_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (in_a),
        .b   (in_b),
        .op  (beat_op),
        .acc (acc),
        .r   (r),
        .f   (f)
    );

    // Next state and the word/beat count to load into the output register
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        res       = r;
        res_beats = CNT_ONE;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (closes) load = 1'b1;
                    else        state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                res       = f;
                res_beats = cnt_inc;
                if (beat && closes) begin
                    load      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Burst accumulator, beat counter and latched op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            cnt  <= '0;
            op_q <= OP_AND;
        end else if (beat) begin
            if (closes) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == IDLE) begin
                acc  <= r;
                cnt  <= CNT_ONE;
                op_q <= op_e'(in_op);
            end else begin
                acc <= f;
                cnt <= cnt_inc;
            end
        end
    end

    // Output register: loads only when free or being consumed this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_zero   <= 1'b1;
            out_parity <= 1'b0;
            out_beats  <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_y      <= res;
            out_zero   <= (res == '0);
            out_parity <= ^res;
            out_beats  <= res_beats;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// burst-list reference model.
module tb_logic_op_pipe;

    localparam int W     = 8;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [1:0]    in_op = '0;
    logic          in_acc = 1'b0, in_last = 1'b0, in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_y;
    logic          out_zero, out_parity, out_valid;
    logic [CW-1:0] out_beats;
    logic          out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    // Reference model: output register contents and list of burst beat results
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_y = '0;
    logic [CW-1:0] m_beats = '0;
    logic          m_burst = 1'b0;
    logic [1:0]    m_op = '0;
    logic [W-1:0]  m_list[$];

    logic_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .out_y(out_y), .out_zero(out_zero),
        .out_parity(out_parity), .out_beats(out_beats),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] beat_res(input logic [W-1:0] a, b, input logic [1:0] op);
        case (op)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic [W-1:0] fold_list(input logic [1:0] op);
        logic [W-1:0] y = m_list[0];
        for (int i = 1; i < m_list.size(); i++) begin
            if (op == 2'd1)      y = y | m_list[i];
            else if (op == 2'd2) y = y ^ m_list[i];
            else                 y = y & m_list[i];
        end
        return y;
    endfunction

    // Advance model by one clock with the current inputs, then clock the DUT.
    task automatic tick();
        logic [W-1:0] r;
        logic take;
        take = in_valid && !(m_valid && !out_ready);
        if (m_valid && out_ready) m_valid = 1'b0;
        if (take) begin
            if (!m_burst) begin
                m_op = in_op;
                m_list.delete();
            end
            r = beat_res(in_a, in_b, m_op);
            m_list.push_back(r);
            if (!in_acc || in_last) begin
                m_valid = 1'b1;
                m_y     = fold_list(m_op);
                m_beats = (m_list.size() > MAXC) ? CW'(MAXC) : CW'(m_list.size());
                m_burst = 1'b0;
            end else begin
                m_burst = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic set_beat(input logic [W-1:0] a, b, input logic [1:0] op,
                            input logic acc, last);
        in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_y !== 8'h00 || out_zero !== 1'b1 || out_parity !== 1'b0 || out_beats !== 2'd0) begin
            bad++; $display("FAIL reset_outs got y=%h z=%b p=%b n=%0d exp y=00 z=1 p=0 n=0", out_y, out_zero, out_parity, out_beats); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        #2 rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_beat(8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0);
        tick();
        total++; if (out_valid !== 1'b1 || out_y !== 8'h30 || out_beats !== 2'd1 || out_zero !== 1'b0 || out_parity !== 1'b0) begin
            bad++; $display("FAIL single_and got v=%b y=%h n=%0d z=%b p=%b exp v=1 y=30 n=1 z=0 p=0", out_valid, out_y, out_beats, out_zero, out_parity); end
        set_beat(8'hF0, 8'h3C, 2'd3, 1'b0, 1'b0);
        tick();
        total++; if (out_y !== 8'hCF || out_parity !== 1'b0 || out_beats !== 2'd1) begin
            bad++; $display("FAIL single_nand got y=%h p=%b n=%0d exp y=cf p=0 n=1", out_y, out_parity, out_beats); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_beat(8'hAA, 8'h0F, 2'd0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'h0A) begin
                bad++; $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b y=%h exp rdy=0 v=1 y=0a", i, in_ready, out_valid, out_y); end
            tick();
        end
        out_ready = 1'b1;
        set_beat(8'h55, 8'h0F, 2'd2, 1'b0, 1'b0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_y !== 8'h5A) begin
            bad++; $display("FAIL bp_no_bubble got v=%b y=%h exp v=1 y=5a", out_valid, out_y); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_xor_burst();
        set_beat(8'h01, 8'h00, 2'd2, 1'b1, 1'b0);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL xor_b1_novalid got=%b exp=0", out_valid); end
        set_beat(8'h02, 8'h00, 2'd0, 1'b1, 1'b0);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL xor_b2_novalid got=%b exp=0", out_valid); end
        set_beat(8'h04, 8'h00, 2'd2, 1'b1, 1'b1);
        tick();
        total++; if (out_valid !== 1'b1 || out_y !== 8'h07 || out_beats !== 2'd3 || out_parity !== 1'b1 || out_zero !== 1'b0) begin
            bad++; $display("FAIL xor_burst got v=%b y=%h n=%0d p=%b z=%b exp v=1 y=07 n=3 p=1 z=0", out_valid, out_y, out_beats, out_parity, out_zero); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_and_zero();
        set_beat(8'hFF, 8'h0F, 2'd0, 1'b1, 1'b0);
        tick();
        set_beat(8'hFF, 8'hF0, 2'd0, 1'b1, 1'b1);
        tick();
        total++; if (out_valid !== 1'b1 || out_y !== 8'h00 || out_zero !== 1'b1 || out_beats !== 2'd2) begin
            bad++; $display("FAIL and_zero got v=%b y=%h z=%b n=%0d exp v=1 y=00 z=1 n=2", out_valid, out_y, out_zero, out_beats); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        logic [W-1:0] a, b, exp_y;
        exp_y = '0;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom_range(0, 255)) & 8'h11;
            b = W'($urandom_range(0, 255)) & 8'h44;
            exp_y = exp_y | a | b;
            set_beat(a, b, 2'd1, 1'b1, i == 5);
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_beats !== 2'd3 || out_y !== exp_y) begin
            bad++; $display("FAIL saturation got v=%b n=%0d y=%h exp v=1 n=3 y=%h", out_valid, out_beats, out_y, exp_y); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        set_beat(8'hF0, 8'h00, 2'd1, 1'b1, 1'b0);
        tick();
        set_beat(8'h0F, 8'h00, 2'd1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_y !== 8'h00 || out_zero !== 1'b1 || out_beats !== 2'd0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL async_reset got v=%b y=%h z=%b n=%0d rdy=%b exp v=0 y=00 z=1 n=0 rdy=0", out_valid, out_y, out_zero, out_beats, in_ready); end
        m_valid = 1'b0; m_burst = 1'b0; m_list.delete();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        set_beat(8'hFF, 8'h3C, 2'd0, 1'b0, 1'b0);
        tick();
        total++; if (out_valid !== 1'b1 || out_y !== 8'h3C || out_beats !== 2'd1) begin
            bad++; $display("FAIL post_reset_beat got v=%b y=%h n=%0d exp v=1 y=3c n=1", out_valid, out_y, out_beats); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_op     = 2'($urandom);
            in_acc    = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 3) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++; if (in_ready !== !(m_valid && !out_ready)) begin
                bad++; errs++; if (errs < 10) $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, !(m_valid && !out_ready)); end
            tick();
            total++; if (out_valid !== m_valid ||
                         (m_valid && (out_y !== m_y || out_beats !== m_beats ||
                                      out_zero !== (m_y == '0) || out_parity !== ^m_y))) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_out cyc=%0d got v=%b y=%h n=%0d z=%b p=%b exp v=%b y=%h n=%0d",
                                        i, out_valid, out_y, out_beats, out_zero, out_parity, m_valid, m_y, m_beats);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_xor_burst();
        test_and_zero();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Parametrised, registered successor to the single-bit combinational AND gate. Handles WIDTH-bit operands and four selectable bitwise ops (AND/OR/XOR/NAND).
- Uses a valid/ready stream interface. Optional multi-beat accumulation folds a burst of results into one output word.
- Sits between operand producers and downstream consumers in the hwsec datapath examples; provides registered result, zero flag and parity.

Parameters:
- WIDTH, 8, operand/result bit width (>=1).
- CNT_W, 4, width of the beat counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  0=AND, 1=OR, 2=XOR, 3=NAND.
- in_acc  input  1  1 = beat belongs to an accumulating burst.
- in_last  input  1  last beat of burst; ignored when in_acc=0.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- out_y  output  WIDTH  registered result.
- out_zero  output  1  out_y == 0.
- out_parity  output  1  XOR-reduce of out_y.
- out_beats  output  CNT_W  beats folded into out_y; saturating.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_y=0, out_zero=1, out_parity=0, out_beats=0. Accumulator and beat counter are cleared; the FSM goes to IDLE.
  - A burst in progress is discarded with no output.
  - in_ready=0 while rst=1 and 1 after deassertion.
- Handshake:
  - An input beat transfers when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready), so a new result may load in the same cycle the old one is consumed.
  - out_valid, out_y, out_zero, out_parity and out_beats are held stable while out_valid && !out_ready.
- Beat result: r = a op b, with NAND = ~(a & b). Widths are exact; no extension.
- FSM states: IDLE, ACCUM.
  - IDLE, beat with in_acc=0: out_y<=r, out_beats<=1, out_valid<=1. Latency is 1 cycle. Stay in IDLE.
  - IDLE, beat with in_acc=1 and in_last=1: behaves as a single-beat result. Stay in IDLE.
  - IDLE, beat with in_acc=1 and in_last=0: acc<=r, cnt<=1, latch op into op_q. Go to ACCUM. No output.
- In ACCUM, each accepted beat uses op_q; in_op is ignored mid-burst. Fold rule is acc<=acc F r, where F=AND for op_q 0/3, OR for 1, XOR for 2. cnt<=sat(cnt+1).
  - Beat with in_last=1: out_y<=acc F r, out_beats<=sat(cnt+1), out_valid<=1. Go to IDLE.
  - Beat with in_acc=0: treated as in_last=1, which closes the burst.
- While in ACCUM with no output pending, in_ready=1.
- out_zero and out_parity are registered together with out_y, in the same cycle.
- Counter saturation: once the count reaches 2^CNT_W-1 it holds there. Accumulation continues unaffected.
- The output register is never overwritten while out_valid && !out_ready.

Decomposition:
- Package logic_op_pkg:
  - op_e enum: OP_AND, OP_OR, OP_XOR, OP_NAND.
  - state_e enum: IDLE, ACCUM.
  - function fold_op(op_e), returning the fold operator.
- Sub-module logic_op_alu (combinational): WIDTH-parametrised, computes r and the fold result. Instantiated once.

Test Plan:
- Reset, then single beats, WIDTH=8, out_ready=1:
  - a=8'hF0, b=8'h3C, op=AND -> next cycle out_y=8'h30, out_beats=1, zero=0, parity=0.
  - Same operands, op=NAND -> out_y=8'hCF.
- Backpressure: out_ready=0 with a result pending -> in_ready=0; out_y held for 5 cycles. Raise out_ready together with a new beat -> the new result appears in the next cycle with no bubble.
- XOR burst of 3 beats, beats 1-2 and 3 as listed:
  - (8'h01,0), (8'h02,0), then (8'h04,0) with last=1.
  - Expected: out_y=8'h07, out_beats=3, parity=1. An in_op change to AND on beat 2 is ignored.
- AND burst giving zero: (FF,0F), (FF,F0) with last -> out_y=8'h00, out_zero=1, out_beats=2.
- Saturation: CNT_W=2, OR burst of 6 beats -> out_beats=3, out_y=OR of all beat results.
- Async reset asserted mid-burst (between clock edges) -> outputs clear immediately. The next single beat is produced with no residual accumulator contribution.
